queue_rr_arbiter: RTL and testbench

QUEUE_RR_ARBITER -- requirements
Module: queue_rr_arbiter

---
 rtl/queue_rr_arbiter.sv | 105 ++++++++++
 tb/tb_queue_rr_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/queue_rr_arbiter.sv
// Round-robin arbiter that feeds a downstream queue of DEPTH entries.
// It tracks the queue occupancy itself, refuses to grant while the queue is
// full, and never grants the same requester on two consecutive edges so the
// requester has a cycle to drop req or present fresh data after a grant.
module queue_rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int DW    = 8,
    parameter int DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic               pop,
    output logic [NREQ-1:0]    grant,
    output logic               q_enq,
    output logic [DW-1:0]      q_data,
    output logic [3:0]         level,
    output logic               stall
);

    localparam int         PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [3:0] DEPTH_L = 4'(DEPTH);

    logic [PW-1:0]   ptr_r;
    logic [NREQ-1:0] elig_s;
    logic            decide_s;
    logic            found_s;
    logic [PW-1:0]   sel_s;
    logic [NREQ-1:0] onehot_s;
    logic [DW-1:0]   sel_data_s;
    logic            pop_eff_s;
    logic [3:0]      level_next_s;

    // A requester granted on the previous edge is masked for one cycle.
    assign elig_s     = req & ~grant;
    assign decide_s   = (elig_s != {NREQ{1'b0}}) && (level < DEPTH_L);
    assign pop_eff_s  = pop && (level != 4'd0);
    assign sel_data_s = req_data[int'(sel_s)*DW +: DW];

    // Search for the first eligible requester after the last granted one.
    always_comb begin
        found_s = 1'b0;
        sel_s   = ptr_r;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found_s && elig_s[(int'(ptr_r) + k) % NREQ]) begin
                found_s = 1'b1;
                sel_s   = PW'((int'(ptr_r) + k) % NREQ);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Decode the selected index into a one-hot grant vector.
    always_comb begin
        onehot_s = {NREQ{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            if (sel_s == PW'(i)) begin
                onehot_s[i] = 1'b1;
            end else begin
                onehot_s[i] = 1'b0;
            end
        end
    end

    // Occupancy update: grant adds one, effective pop removes one, both cancel.
    always_comb begin
        level_next_s = level;
        if (decide_s && !pop_eff_s) begin
            level_next_s = level + 4'd1;
        end else if (!decide_s && pop_eff_s) begin
            level_next_s = level - 4'd1;
        end else begin
            level_next_s = level;
        end
    end

    // Registered grant/enqueue outputs, round-robin pointer and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant  <= {NREQ{1'b0}};
            q_enq  <= 1'b0;
            q_data <= {DW{1'b0}};
            ptr_r  <= PW'(NREQ - 1);
            level  <= 4'd0;
            stall  <= 1'b0;
        end else begin
            if (decide_s) begin
                grant  <= onehot_s;
                q_enq  <= 1'b1;
                q_data <= sel_data_s;
                ptr_r  <= sel_s;
            end else begin
                grant  <= {NREQ{1'b0}};
                q_enq  <= 1'b0;
                q_data <= q_data;
                ptr_r  <= ptr_r;
            end
            level <= level_next_s;
            stall <= (req != {NREQ{1'b0}}) && (level == DEPTH_L);
        end
    end

endmodule

// File: tb/tb_queue_rr_arbiter.sv
// Directed bench for queue_rr_arbiter. Expected grants are queued by the
// stimulus thread; a monitor thread checks each enqueue the DUT presents.
module tb_queue_rr_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic        pop;
    logic [3:0]  grant;
    logic        q_enq;
    logic [7:0]  q_data;
    logic [3:0]  level;
    logic        stall;

    typedef struct packed {
        logic [3:0] g;
        logic [7:0] d;
    } exp_t;

    exp_t sb_q[$];
    int   checks;
    int   failures;
    bit   done;

    queue_rr_arbiter #(.NREQ(4), .DW(8), .DEPTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .pop      (pop),
        .grant    (grant),
        .q_enq    (q_enq),
        .q_data   (q_data),
        .level    (level),
        .stall    (stall)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_grant(input logic [3:0] g, input logic [7:0] d);
        exp_t e;
        e.g = g;
        e.d = d;
        sb_q.push_back(e);
    endtask

    task automatic set_d(input int i, input logic [7:0] v);
        req_data[i*8 +: 8] = v;
    endtask

    task automatic stimulus();
        rst      = 1'b0;
        req      = 4'b0000;
        req_data = 32'h0;
        pop      = 1'b0;
        #3;
        chk("reset_grant", {28'h0, grant}, 32'h0);
        chk("reset_q_enq", {31'h0, q_enq}, 32'h0);
        chk("reset_q_data", {24'h0, q_data}, 32'h0);
        chk("reset_level", {28'h0, level}, 32'h0);
        chk("reset_stall", {31'h0, stall}, 32'h0);
        #19 rst = 1'b1;

        // All four requesting from reset: 0,1,2,3,0,1,2,3 then full.
        req = 4'b1111;
        set_d(0, 8'hA0); set_d(1, 8'hA1); set_d(2, 8'hA2); set_d(3, 8'hA3);
        for (int r = 0; r < 2; r++) begin
            expect_grant(4'b0001, 8'hA0);
            expect_grant(4'b0010, 8'hA1);
            expect_grant(4'b0100, 8'hA2);
            expect_grant(4'b1000, 8'hA3);
        end
        tick();
        chk("all_first_grant", {28'h0, grant}, 32'h1);
        repeat (7) tick();
        chk("all_level8", {28'h0, level}, 32'h8);
        tick();
        chk("full_stall", {31'h0, stall}, 32'h1);
        chk("full_no_enq", {31'h0, q_enq}, 32'h0);
        chk("full_level_hold", {28'h0, level}, 32'h8);
        tick();
        chk("full_no_enq2", {31'h0, q_enq}, 32'h0);

        // Full with a pop: no grant at that edge, grant on the next.
        req = 4'b0100;
        set_d(2, 8'hB2);
        pop = 1'b1;
        tick();
        pop = 1'b0;
        chk("fullpop_level7", {28'h0, level}, 32'h7);
        chk("fullpop_no_grant", {28'h0, grant}, 32'h0);
        expect_grant(4'b0100, 8'hB2);
        tick();
        chk("fullpop_grant", {28'h0, grant}, 32'h4);
        chk("fullpop_level8", {28'h0, level}, 32'h8);
        req = 4'b0000;
        tick();
        pop = 1'b1;
        repeat (8) tick();
        pop = 1'b0;
        chk("drain_level0", {28'h0, level}, 32'h0);

        // Single requester: granted, masked a cycle, then new data granted.
        req = 4'b0001;
        set_d(0, 8'h11);
        expect_grant(4'b0001, 8'h11);
        tick();
        set_d(0, 8'h22);
        chk("single_grant", {28'h0, grant}, 32'h1);
        chk("single_data", {24'h0, q_data}, 32'h11);
        tick();
        chk("single_masked", {28'h0, grant}, 32'h0);
        chk("single_masked_enq", {31'h0, q_enq}, 32'h0);
        expect_grant(4'b0001, 8'h22);
        tick();
        chk("single_regrant", {28'h0, grant}, 32'h1);
        chk("single_level2", {28'h0, level}, 32'h2);
        req = 4'b0000;
        tick();

        // Build level to 5, then grant and pop on the same edge.
        req = 4'b1110;
        set_d(1, 8'hC1); set_d(2, 8'hC2); set_d(3, 8'hC3);
        expect_grant(4'b0010, 8'hC1);
        expect_grant(4'b0100, 8'hC2);
        expect_grant(4'b1000, 8'hC3);
        repeat (3) tick();
        chk("simul_pre_level5", {28'h0, level}, 32'h5);
        pop = 1'b1;
        expect_grant(4'b0010, 8'hC1);
        tick();
        pop = 1'b0;
        req = 4'b0000;
        chk("simul_level5", {28'h0, level}, 32'h5);
        chk("simul_enq", {31'h0, q_enq}, 32'h1);
        tick();
        pop = 1'b1;
        repeat (5) tick();
        chk("drain2_level0", {28'h0, level}, 32'h0);

        // Pop while empty must not underflow.
        tick();
        pop = 1'b0;
        chk("empty_pop_level", {28'h0, level}, 32'h0);
        chk("empty_pop_enq", {31'h0, q_enq}, 32'h0);

        // Burst to level 6, then asynchronous reset mid-burst.
        req = 4'b1111;
        set_d(0, 8'hE0); set_d(1, 8'hE1); set_d(2, 8'hE2); set_d(3, 8'hE3);
        expect_grant(4'b0100, 8'hE2);
        expect_grant(4'b1000, 8'hE3);
        expect_grant(4'b0001, 8'hE0);
        expect_grant(4'b0010, 8'hE1);
        expect_grant(4'b0100, 8'hE2);
        expect_grant(4'b1000, 8'hE3);
        repeat (6) tick();
        chk("burst_level6", {28'h0, level}, 32'h6);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        chk("midrst_grant", {28'h0, grant}, 32'h0);
        chk("midrst_enq", {31'h0, q_enq}, 32'h0);
        chk("midrst_data", {24'h0, q_data}, 32'h0);
        chk("midrst_level", {28'h0, level}, 32'h0);
        chk("midrst_stall", {31'h0, stall}, 32'h0);
        req = 4'b1001;
        set_d(0, 8'hF0); set_d(3, 8'hF3);
        @(negedge clk);
        #1 rst = 1'b1;
        expect_grant(4'b0001, 8'hF0);
        tick();
        chk("postrst_grant", {28'h0, grant}, 32'h1);
        req = 4'b0000;
        repeat (2) tick();
        chk("sb_empty", 32'(sb_q.size()), 32'h0);
        done = 1'b1;
    endtask

    task automatic monitor();
        exp_t e;
        while (!done) begin
            @(negedge clk);
            if (rst) begin
                chk("enq_vs_grant", {31'h0, q_enq}, {31'h0, |grant});
                if (q_enq) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_enq", {28'h0, grant}, 32'h0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("sb_grant", {28'h0, grant}, {28'h0, e.g});
                        chk("sb_data", {24'h0, q_data}, {24'h0, e.d});
                    end
                end
            end
        end
    endtask

    // Run stimulus and monitor concurrently, then report.
    initial begin
        checks   = 0;
        failures = 0;
        done     = 1'b0;
        fork
            stimulus();
            monitor();
        join
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
